dm_arbiter: RTL and testbench

Round-robin arbiter sharing one synchronous data memory among `NUM_CORES` matrix-multiply processor cores. It serialises core read/write requests onto the single memory port and returns read data with a per-core acknowledge. It also drives each core's 2-bit `status` to run, stall or stop it, and aggregates per-core `end_process` into a global done flag. It sits between the core array and the shared data RAM.

---
 rtl/dm_arb_pkg.sv | 25 ++
 rtl/rr_picker.sv | 30 +++
 rtl/dm_arbiter.sv | 139 +++++++++++++
 tb/tb_dm_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ACCESS,
    RESP,
    DONE
  } state_e;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;
  localparam logic [1:0] ST_STOP = 2'b11;

  // A core that has just been acked is free to run even if it re-asserts req the same cycle.
  function automatic logic [1:0] status_of(state_e st, logic req, logic acked, logic ended);
    if (st == IDLE) return ST_IDLE;
    if (st == DONE || ended) return ST_STOP;
    if (req && !acked) return ST_HOLD;
    return ST_RUN;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int unsigned IdxW = $clog2(N);

  logic [IdxW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = ptr;
    for (int k = 0; k < N; k++) begin
      if (!any && eligible[j]) begin
        any      = 1'b1;
        idx      = j;
        grant[j] = 1'b1;
      end
      j = (j == IdxW'(N - 1)) ? '0 : j + 1'b1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter serialising core accesses onto one shared synchronous data RAM,
// with per-core run/stall/stop status and a global completion flag.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]        core_end,
  output logic [2*NUM_CORES-1:0]      core_status,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        all_done
);
  localparam int unsigned IdxW = $clog2(NUM_CORES);

  state_e               state_q;
  logic [IdxW-1:0]      rr_ptr_q;
  logic [IdxW-1:0]      gnt_idx_q;
  logic                 gnt_we_q;
  logic [NUM_CORES-1:0] ended_q;
  logic [NUM_CORES-1:0] ack_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 mem_en_q;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_W-1:0]    mem_wdata_q;
  logic                 all_done_q;

  logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
  logic [DATA_W-1:0]    wdata_arr [NUM_CORES];
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] pick_grant;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_any;
  logic                 pick_we;
  logic [IdxW-1:0]      ptr_next;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    assign addr_arr[i]           = core_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i]          = core_wdata[i*DATA_W +: DATA_W];
    assign core_status[2*i +: 2] = status_of(state_q, core_req[i], ack_q[i], ended_q[i]);
  end

  // The just-acked core sits out one arbitration round.
  assign eligible = core_req & ~ended_q & ~ack_q;
  assign pick_we  = |(pick_grant & core_we);
  assign ptr_next = (pick_idx == IdxW'(NUM_CORES - 1)) ? '0 : pick_idx + 1'b1;

  rr_picker #(
    .N(NUM_CORES)
  ) u_picker (
    .eligible(eligible),
    .ptr     (rr_ptr_q),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      gnt_we_q    <= 1'b0;
      ended_q     <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      all_done_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      if (state_q != IDLE) ended_q <= ended_q | core_end;
      case (state_q)
        IDLE: begin
          if (start) state_q <= ARB;
        end
        ARB: begin
          if (&ended_q) begin
            state_q    <= DONE;
            all_done_q <= 1'b1;
          end else if (pick_any) begin
            state_q     <= ACCESS;
            gnt_idx_q   <= pick_idx;
            gnt_we_q    <= pick_we;
            rr_ptr_q    <= ptr_next;
            mem_en_q    <= 1'b1;
            mem_we_q    <= pick_we;
            mem_addr_q  <= addr_arr[pick_idx];
            mem_wdata_q <= wdata_arr[pick_idx];
          end
        end
        ACCESS: begin
          state_q  <= RESP;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
        RESP: begin
          if (!gnt_we_q) rdata_q <= mem_rdata;
          ack_q[gnt_idx_q] <= 1'b1;
          state_q          <= ARB;
        end
        DONE: begin
          if (start) begin
            ended_q    <= '0;
            all_done_q <= 1'b0;
            state_q    <= ARB;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_ack   = ack_q;
  assign core_rdata = rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign all_done   = all_done_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a transaction-level model predicts grants, memory
// accesses, acks and status; monitors compare them against the DUT each cycle.
module tb_dm_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clock = 1'b0;
  logic            rst_n;
  logic            start;
  logic [N-1:0]    core_req, core_we, core_end;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [2*N-1:0]  core_status;
  logic [N-1:0]    core_ack;
  logic [DW-1:0]   core_rdata;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            all_done;

  dm_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_end   (core_end),
    .core_status(core_status),
    .core_ack   (core_ack),
    .core_rdata (core_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .all_done   (all_done)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a, ~a};
  endfunction

  // Environment RAM: registered read, valid one cycle after the enable edge.
  logic [15:0] ram [256];
  bit          ram_wr [256];
  logic [15:0] ram_q = '0;
  assign mem_rdata = ram_q;
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[7:0]]    <= mem_wdata;
        ram_wr[mem_addr[7:0]] <= 1'b1;
      end else begin
        ram_q <= ram_wr[mem_addr[7:0]] ? ram[mem_addr[7:0]] : init_val(mem_addr[7:0]);
      end
    end
  end

  // Reference model: mode 0 idle, 1 running, 2 done.
  typedef struct {
    int          core;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          cyc;
  } txn_t;

  txn_t        exp_ack_q[$];
  txn_t        exp_mem_q[$];
  txn_t        mt, gt;
  int          cyc = 0;
  int          m_mode, m_busy, m_mask, m_ptr, m_cur, m_blocked, m_c;
  bit          m_found;
  logic [3:0]  m_ended, m_old;
  logic [15:0] m_last;
  logic [15:0] m_mem [256];
  bit          m_wr [256];

  initial forever begin
    @(posedge clock or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_busy = 0; m_mask = -1; m_ptr = 0; m_cur = 0;
      m_ended = '0; m_last = '0;
      exp_ack_q.delete();
      exp_mem_q.delete();
    end else begin
      cyc++;
      m_old = m_ended;
      if (m_mode != 0) m_ended = m_ended | core_end;
      if (m_mode == 0) begin
        if (start) m_mode = 1;
      end else if (m_mode == 2) begin
        if (start) begin
          m_ended = '0;
          m_mode  = 1;
        end
      end else if (m_busy == 2) begin
        m_busy = 1;
      end else if (m_busy == 1) begin
        m_busy = 0;
        m_mask = m_cur;
      end else begin
        m_blocked = m_mask;
        m_mask    = -1;
        if (m_old == 4'hF) begin
          m_mode = 2;
        end else begin
          m_found = 0;
          for (int k = 0; k < N; k++) begin
            m_c = (m_ptr + k) % N;
            if (!m_found && core_req[m_c] && !m_old[m_c] && m_c != m_blocked) begin
              m_found  = 1;
              m_cur    = m_c;
              m_ptr    = (m_c + 1) % N;
              m_busy   = 2;
              gt.core  = m_c;
              gt.we    = core_we[m_c];
              gt.addr  = core_addr[m_c*AW +: AW];
              gt.wdata = core_wdata[m_c*DW +: DW];
              if (gt.we) begin
                m_mem[gt.addr[7:0]] = gt.wdata;
                m_wr[gt.addr[7:0]]  = 1'b1;
              end else begin
                m_last = m_wr[gt.addr[7:0]] ? m_mem[gt.addr[7:0]] : init_val(gt.addr[7:0]);
              end
              gt.rdata = m_last;
              gt.cyc   = cyc;
              exp_mem_q.push_back(gt);
              gt.cyc   = cyc + 2;
              exp_ack_q.push_back(gt);
            end
          end
        end
      end
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  logic [7:0] exp_st;
  initial forever begin
    @(negedge clock);
    if (core_ack != '0) begin
      if (exp_ack_q.size() == 0) begin
        check("unexpected_ack", core_ack, 0);
      end else begin
        mt = exp_ack_q.pop_front();
        check("ack_core", core_ack, 64'(1) << mt.core);
        check("ack_cycle", cyc, mt.cyc);
        check("ack_rdata", core_rdata, mt.rdata);
      end
    end else if (exp_ack_q.size() != 0 && exp_ack_q[0].cyc < cyc) begin
      mt = exp_ack_q.pop_front();
      check("missing_ack", core_ack, 64'(1) << mt.core);
    end
    if (mem_en) begin
      if (exp_mem_q.size() == 0) begin
        check("unexpected_mem_en", mem_en, 0);
      end else begin
        mt = exp_mem_q.pop_front();
        check("mem_cycle", cyc, mt.cyc);
        check("mem_addr", mem_addr, mt.addr);
        check("mem_we", mem_we, mt.we);
        if (mt.we) check("mem_wdata", mem_wdata, mt.wdata);
      end
    end else begin
      check("mem_we_idle", mem_we, 0);
      if (exp_mem_q.size() != 0 && exp_mem_q[0].cyc < cyc) begin
        mt = exp_mem_q.pop_front();
        check("missing_mem_en", mem_en, 1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_mode == 0) exp_st[2*i +: 2] = 2'b00;
      else if (m_mode == 2 || m_ended[i]) exp_st[2*i +: 2] = 2'b11;
      else if (core_req[i] && m_mask != i) exp_st[2*i +: 2] = 2'b10;
      else exp_st[2*i +: 2] = 2'b01;
    end
    check("status", core_status, exp_st);
    check("all_done", all_done, m_mode == 2);
  end

  // Stimulus helpers: inputs change 2 time units after the rising edge.
  int ack_log[$];

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_req(input int c, input logic we, input logic [15:0] a, input logic [15:0] d);
    core_req[c]            = 1'b1;
    core_we[c]             = we;
    core_addr[c*AW +: AW]  = a;
    core_wdata[c*DW +: DW] = d;
  endtask

  task automatic serve(input int budget);
    int n = 0;
    while (core_req != '0 && n < budget) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (core_req[i] && core_ack[i]) begin
          core_req[i] = 1'b0;
          ack_log.push_back(i);
        end
      end
      n++;
    end
    check("serve_timeout", core_req, 0);
  endtask

  task automatic restart();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, core_ack, 0);
    check({tag, "_rdata"}, core_rdata, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_all_done"}, all_done, 0);
    check({tag, "_status"}, core_status, 0);
  endtask

  int ack_cnt [N];
  int total;
  int n;

  initial begin
    rst_n = 1'b0; start = 1'b0; core_req = '0; core_we = '0;
    core_addr = '0; core_wdata = '0; core_end = '0;
    repeat (2) tick();
    check_reset_outputs("por");
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;

    // Single read, then write followed by read-back.
    set_req(1, 1'b0, 16'h0010, 16'h0000);
    serve(20);
    check("single_read_data", core_rdata, 16'hBEEF);
    set_req(0, 1'b1, 16'h0005, 16'h1234);
    serve(20);
    set_req(0, 1'b0, 16'h0005, 16'h0000);
    serve(20);
    check("write_read_data", core_rdata, 16'h1234);

    // Contention right after reset: order 0, 2, 3.
    restart();
    ack_log.delete();
    set_req(0, 1'b0, 16'h0001, 16'h0);
    set_req(2, 1'b1, 16'h0002, 16'hAAAA);
    set_req(3, 1'b0, 16'h0002, 16'h0);
    serve(40);
    check("contention_count", ack_log.size(), 3);
    check("contention_order0", ack_log[0], 0);
    check("contention_order1", ack_log[1], 2);
    check("contention_order2", ack_log[2], 3);

    // Fairness: all cores request continuously for 12 grants.
    ack_log.delete();
    total = 0;
    for (int i = 0; i < N; i++) begin
      ack_cnt[i] = 0;
      set_req(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
    end
    for (int t = 0; t < 200 && total < 12; t++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (core_ack[i]) begin
          ack_cnt[i]++;
          total++;
          ack_log.push_back(i);
          set_req(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
        end
      end
      if (total >= 12) core_req = '0;
    end
    check("fair_total", total, 12);
    for (int i = 0; i < N; i++) check("fair_count", ack_cnt[i], 3);
    for (int j = 0; j < 12; j++) check("fair_order", ack_log[j], j % N);

    // Random traffic with stray start pulses.
    for (int t = 0; t < 400; t++) begin
      tick();
      start = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < N; i++) begin
        if (core_req[i] && core_ack[i]) core_req[i] = 1'b0;
        if (!core_req[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
      end
    end
    start = 1'b0;
    serve(100);

    // Completion: cores end in order 3, 1, 0, 2; core 3 keeps requesting after ending.
    core_end[3] = 1'b1; tick(); core_end = '0;
    set_req(3, 1'b0, 16'h0007, 16'h0);
    repeat (6) tick();
    core_end[1] = 1'b1; tick(); core_end = '0;
    core_end[0] = 1'b1; tick(); core_end = '0;
    repeat (3) tick();
    core_end[2] = 1'b1; tick(); core_end = '0;
    repeat (4) tick();
    check("done_flag", all_done, 1);
    check("done_status", core_status, 8'hFF);
    core_req = '0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("restart_status", core_status, 8'h55);
    check("restart_all_done", all_done, 0);
    set_req(3, 1'b0, 16'h0010, 16'h0);
    serve(20);

    // Reset asserted during the access cycle drops the transaction.
    set_req(2, 1'b0, 16'h0003, 16'h0);
    n = 0;
    while (!mem_en && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("access_seen", mem_en, 1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    core_req = '0;
    @(posedge clock);
    #2 rst_n = 1'b1;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
